// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write master.
// Holds the controller state encoding and the framing constants
// (phases per SCL bit, bytes per transfer).
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_ACK,
        ST_STOP
    } state_e;

    localparam int PHASES_PER_BIT = 4;
    localparam int BYTES_PER_XFER = 3;

    localparam logic [1:0] LAST_PHASE = 2'(PHASES_PER_BIT - 1);
    localparam logic [1:0] LAST_BYTE  = 2'(BYTES_PER_XFER - 1);

endpackage

// File: rtl/i2c_write_master.sv
// I2C single-register write master.
// A transfer sends START, {dev_addr,W}, reg_addr, data (each followed by
// an ACK slot) and STOP. Bus timing comes from an external divider: every
// edge of div_clk_i is one phase tick, and four ticks make one SCL bit.
//
// Ports
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   div_clk_i           divider output (synchronous to clk_i)
//   div_hold_o/reset_o  keep the divider parked while idle
//   req_valid_i/ready_o request handshake
//   dev_addr_i          7-bit target address
//   reg_addr_i, data_i  register address and write data
//   done_o              one-cycle pulse at the end of a transfer
//   nack_o              any NACK seen in the last transfer (sticky)
//   scl_o, sda_o        open-drain controls: 0 = pull low, 1 = release
//   sda_i               sampled SDA line
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter bit IGNORE_NACK = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       div_clk_i,
    output logic       div_hold_o,
    output logic       div_reset_o,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [6:0] dev_addr_i,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] data_i,
    output logic       done_o,
    output logic       nack_o,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       sda_i
);

    state_e          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bit_q,   bit_d;
    logic [1:0]      byte_q,  byte_d;
    logic [2:0][7:0] bytes_q, bytes_d;
    logic            nack_q,  nack_d;
    logic            ackbad_q, ackbad_d;   // NACK seen in the current ACK slot
    logic            done_q,  done_d;
    logic            div_q;
    logic            rdy_en_q;             // holds ready low until the first edge out of reset

    logic            tick;
    logic            accept;
    logic [7:0]      cur_byte;
    logic            scl_c, sda_c;

    assign tick   = (div_clk_i != div_q);
    assign accept = req_valid_i && req_ready_o;

    assign req_ready_o = (state_q == ST_IDLE) && !done_q && rdy_en_q;
    assign done_o      = done_q;
    assign nack_o      = nack_q;
    assign div_hold_o  = (state_q == ST_IDLE);
    assign div_reset_o = (state_q == ST_IDLE);
    assign scl_o       = scl_c;
    assign sda_o       = sda_c;

    always_comb begin
        case (byte_q)
            2'd0:    cur_byte = bytes_q[0];
            2'd1:    cur_byte = bytes_q[1];
            default: cur_byte = bytes_q[2];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        bytes_d  = bytes_q;
        nack_d   = nack_q;
        ackbad_d = ackbad_q;
        done_d   = 1'b0;
        scl_c    = 1'b1;
        sda_c    = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_START;
                    phase_d    = 2'd0;
                    bit_d      = 3'd7;
                    byte_d     = 2'd0;
                    bytes_d[0] = {dev_addr_i, 1'b0};
                    bytes_d[1] = reg_addr_i;
                    bytes_d[2] = data_i;
                    nack_d     = 1'b0;
                    ackbad_d   = 1'b0;
                end
            end

            ST_START: begin
                // SDA falls while SCL is high, then SCL drops
                case (phase_q)
                    2'd0:    begin scl_c = 1'b1; sda_c = 1'b1; end
                    2'd1:    begin scl_c = 1'b1; sda_c = 1'b0; end
                    default: begin scl_c = 1'b0; sda_c = 1'b0; end
                endcase
                if (tick) begin
                    if (phase_q == 2'd2) begin
                        state_d = ST_DATA;
                        phase_d = 2'd0;
                        bit_d   = 3'd7;
                        byte_d  = 2'd0;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end

            ST_DATA: begin
                scl_c = (phase_q == 2'd1) || (phase_q == 2'd2);
                sda_c = cur_byte[bit_q];
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == LAST_PHASE) begin
                        if (bit_q == 3'd0) begin
                            state_d = ST_ACK;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                end
            end

            ST_ACK: begin
                scl_c = (phase_q == 2'd1) || (phase_q == 2'd2);
                sda_c = 1'b1;
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd2) begin
                        ackbad_d = sda_i;
                        if (sda_i) nack_d = 1'b1;
                    end
                    if (phase_q == LAST_PHASE) begin
                        if ((ackbad_q && !IGNORE_NACK) || (byte_q == LAST_BYTE)) begin
                            state_d = ST_STOP;
                        end else begin
                            state_d = ST_DATA;
                            byte_d  = byte_q + 2'd1;
                            bit_d   = 3'd7;
                        end
                    end
                end
            end

            ST_STOP: begin
                // SCL rises with SDA low, then SDA rises while SCL is high
                case (phase_q)
                    2'd0:    begin scl_c = 1'b0; sda_c = 1'b0; end
                    2'd1:    begin scl_c = 1'b1; sda_c = 1'b0; end
                    default: begin scl_c = 1'b1; sda_c = 1'b1; end
                endcase
                if (tick) begin
                    if (phase_q == 2'd2) begin
                        state_d = ST_IDLE;
                        phase_d = 2'd0;
                        done_d  = 1'b1;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                phase_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            phase_q  <= 2'd0;
            bit_q    <= 3'd0;
            byte_q   <= 2'd0;
            bytes_q  <= '0;
            nack_q   <= 1'b0;
            ackbad_q <= 1'b0;
            done_q   <= 1'b0;
            div_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            bytes_q  <= bytes_d;
            nack_q   <= nack_d;
            ackbad_q <= ackbad_d;
            done_q   <= done_d;
            div_q    <= div_clk_i;
            rdy_en_q <= 1'b1;
        end
    end

endmodule
